// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Latency: start sampled on E0, result and done pulse visible after edge E(WIDTH), i.e. WIDTH+1 edges.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored (not queued) while busy.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             bit_s;
  logic             carry_n;
  logic             load;

  // Single full-adder cell on the current LSBs of the operand shift registers.
  always_comb begin
    bit_s   = sa_q[0] ^ sb_q[0] ^ carry_q;
    carry_n = (carry_q & (sa_q[0] ^ sb_q[0])) | (sa_q[0] & sb_q[0]);
  end

  // Next-state and datapath: shift one bit per SHIFT cycle, publish result on the last bit.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    load    = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = carry_n;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB; carry_n is the carry out of it.
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          c_out_d = carry_n;
          ovf_d   = carry_q ^ carry_n;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Subtract is A + ~B + ~c_in, so the borrow-in is inverted into the carry flop.
    if (load) begin
      sa_d    = a;
      sb_d    = sub ? ~b : b;
      carry_d = sub ? ~c_in : c_in;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  // State and datapath registers; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub at WIDTH=8 (directed, corner, random) and WIDTH=4 (exhaustive).
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ovf8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .overflow(ovf4)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] esum;
    logic       ecout;
    logic       eovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: unsigned sum for sum/c_out, signed integer range for overflow.
  function automatic void model(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic ci, output logic [31:0] esum, output logic eco, output logic eov);
    longint m, bb, tot, sa, sb, r;
    m   = longint'(1) << w;
    bb  = s ? (m - 1 - longint'(b)) : longint'(b);
    tot = longint'(a) + bb + (s ? longint'(!ci) : longint'(ci));
    esum = 32'(tot % m);
    eco  = (tot >= m);
    sa = a[w-1] ? longint'(a) - m : longint'(a);
    sb = b[w-1] ? longint'(b) - m : longint'(b);
    r  = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    eov = (r < -(m / 2)) || (r >= (m / 2));
  endfunction

  // Run one WIDTH=8 operation from IDLE/DONE, checking timing, pulse width and result.
  task automatic op8(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic [7:0] esum, input logic eco, input logic eov);
    int n, busy_n;
    sub8 = s; a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 1; busy_n = 0;
    while (!done8 && n < 40) begin
      if (busy8) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      chk({name, " timeout"}, 32'(done8), 32'd1);
      return;
    end
    chk({name, " latency"}, 32'(n), 32'd9);
    chk({name, " busy_cycles"}, 32'(busy_n), 32'd8);
    chk({name, " busy_with_done"}, 32'(busy8), 32'd0);
    chk({name, " sum"}, 32'(sum8), 32'(esum));
    chk({name, " c_out"}, 32'(cout8), 32'(eco));
    chk({name, " overflow"}, 32'(ovf8), 32'(eov));
    @(posedge clk); #1;
    chk({name, " done_width"}, 32'(done8), 32'd0);
  endtask

  // One WIDTH=4 operation; result compared to the model.
  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b, input logic ci);
    int n;
    logic [31:0] es;
    logic eco, eov;
    model(4, s, 32'(a), 32'(b), ci, es, eco, eov);
    sub4 = s; a4 = a; b4 = b; cin4 = ci; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20 || n != 5 || {sum4, cout4, ovf4} !== {es[3:0], eco, eov}) begin
      errors++;
      $display("FAIL w4 sub=%0d a=%0h b=%0h ci=%0d: got sum=%0h co=%0d ov=%0d lat=%0d expected sum=%0h co=%0d ov=%0d lat=5",
               s, a, b, ci, sum4, cout4, ovf4, n, es[3:0], eco, eov);
    end
    checks++;
  endtask

  initial begin
    int n, dn;
    logic [31:0] es;
    logic eco, eov, rs, rci;
    logic [7:0] ra, rb;

    vecs[0] = '{1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Start held high during reset must be ignored.
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    rst = 1'b0;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset outputs", {23'd0, sum8, cout8}, 32'd0);
    chk("reset overflow", 32'(ovf8), 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++)
      op8($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
          vecs[i].esum, vecs[i].ecout, vecs[i].eovf);

    // Start mid-operation is ignored; operand change after load has no effect.
    sub8 = 1'b0; a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 1;
    repeat (3) begin @(posedge clk); #1; n++; end
    a8 = 8'hAA; start8 = 1'b1;
    @(posedge clk); #1; n++;
    start8 = 1'b0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("ignore latency", 32'(n), 32'd9);
    chk("ignore sum", 32'(sum8), 32'h7F);
    dn = 0;
    repeat (15) begin @(posedge clk); #1; if (done8) dn++; end
    chk("ignore extra_done", 32'(dn), 32'd0);

    // Back-to-back: start during DONE restarts with no idle gap.
    sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b first sum", 32'(sum8), 32'h30);
    sub8 = 1'b1; a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b no_gap busy", 32'(busy8), 32'd1);
    chk("b2b no_gap done", 32'(done8), 32'd0);
    n = 1;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b second latency", 32'(n), 32'd9);
    chk("b2b second result", {23'd0, sum8, cout8, ovf8}, {23'd0, 8'h7F, 1'b1, 1'b1});
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done pulse.
    sub8 = 1'b0; a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst outputs", {23'd0, sum8, cout8, ovf8}, 32'd0);
    dn = 0;
    repeat (15) begin @(posedge clk); #1; if (done8) dn++; end
    chk("midrst no_done", 32'(dn), 32'd0);
    op8("after_rst", 1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

    // Reset during the DONE cycle.
    sub8 = 1'b0; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("donerst done", 32'(done8), 32'd0);
    chk("donerst outputs", {23'd0, sum8, cout8, ovf8}, 32'd0);

    // Random WIDTH=8 against the model.
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom); rci = 1'($urandom);
      ra = 8'($urandom); rb = 8'($urandom);
      model(8, rs, 32'(ra), 32'(rb), rci, es, eco, eov);
      op8($sformatf("rand%0d", i), rs, ra, rb, rci, es[7:0], eco, eov);
    end

    // Exhaustive WIDTH=4.
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int ia = 0; ia < 16; ia++)
          for (int ib = 0; ib < 16; ib++)
            op4(1'(s), 4'(ia), 4'(ib), 1'(ci));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
